// File: rtl/inhibitory_layer.sv
// Time-multiplexed layer of leaky integrate-and-fire inhibitory neurons.
// One shared saturating leak/integrate datapath visits one neuron per enabled cycle.
module inhibitory_layer #(
  parameter int N_NEURONS    = 100,
  parameter int POTENT_WIDTH = 16,
  parameter int FRAC_BITS    = 8,
  parameter int REFRAC_LEN   = 2,
  parameter int W_IN         = 5120,
  parameter int V_REST       = -15360,
  parameter int V_RESET      = -11520,
  parameter int V_THRES      = -10240,
  parameter int LEAK         = 254
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 step_start,
  input  logic [N_NEURONS-1:0] spike_in,
  output logic                 busy,
  output logic                 step_done,
  output logic [N_NEURONS-1:0] spike_out,
  output logic                 spike_any
);

  // state  | meaning
  // S_IDLE | waiting for step_start
  // S_RUN  | updating neuron idx, one per enabled cycle
  // S_DONE | publishing shadow spikes, pulsing step_done

  localparam int IW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
  localparam int CW = (REFRAC_LEN > 0) ? $clog2(REFRAC_LEN + 1) : 1;
  localparam int XW = POTENT_WIDTH + 34;

  typedef logic signed [POTENT_WIDTH-1:0] pot_t;
  typedef logic signed [XW-1:0]           wide_t;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam wide_t P_MAX = {{(XW-POTENT_WIDTH+1){1'b0}}, {(POTENT_WIDTH-1){1'b1}}};
  localparam wide_t P_MIN = {{(XW-POTENT_WIDTH+1){1'b1}}, {(POTENT_WIDTH-1){1'b0}}};
  localparam wide_t W_ZERO = '0;
  localparam wide_t LEAK_W = XW'(LEAK);
  localparam pot_t  VREST_P  = POTENT_WIDTH'(V_REST);
  localparam pot_t  VRESET_P = POTENT_WIDTH'(V_RESET);
  localparam pot_t  VTHRES_P = POTENT_WIDTH'(V_THRES);
  localparam pot_t  WIN_P    = POTENT_WIDTH'(W_IN);
  localparam logic [CW-1:0] REFRAC_C = CW'(REFRAC_LEN);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_NEURONS - 1);

  function automatic wide_t ext(input pot_t p);
    return {{(XW-POTENT_WIDTH){p[POTENT_WIDTH-1]}}, p};
  endfunction

  function automatic pot_t sat(input wide_t x);
    if (x > P_MAX) return P_MAX[POTENT_WIDTH-1:0];
    if (x < P_MIN) return P_MIN[POTENT_WIDTH-1:0];
    return x[POTENT_WIDTH-1:0];
  endfunction

  state_t               state, state_nxt;
  logic [IW-1:0]        idx;
  pot_t                 v_mem [N_NEURONS];
  logic [CW-1:0]        c_mem [N_NEURONS];
  logic [N_NEURONS-1:0] spk_lat, shadow;

  pot_t          v_cur, d_sat, leak, u, v_nxt;
  logic [CW-1:0] c_cur, c_nxt;
  wide_t         prod, w_add;
  logic          s_cur, fire;

  // Every sum saturates, including the distance from rest fed to the multiplier.
  always_comb begin
    v_cur = v_mem[idx];
    c_cur = c_mem[idx];
    s_cur = spk_lat[idx];
    d_sat = sat(ext(v_cur) - ext(VREST_P));
    prod  = ext(d_sat) * LEAK_W;
    leak  = sat(ext(VREST_P) + (prod >>> FRAC_BITS));
    w_add = s_cur ? ext(WIN_P) : W_ZERO;
    u     = sat(ext(leak) + w_add);
    fire  = 1'b0;
    v_nxt = leak;
    c_nxt = c_cur;
    if (c_cur != '0) begin
      c_nxt = c_cur - CW'(1);
    end else if (u >= VTHRES_P) begin
      fire  = 1'b1;
      v_nxt = VRESET_P;
      c_nxt = REFRAC_C;
    end else begin
      v_nxt = u;
    end
  end

  always_comb begin
    state_nxt = state;
    if (en) begin
      case (state)
        S_IDLE:  if (step_start) state_nxt = S_RUN;
        S_RUN:   if (idx == LAST_IDX) state_nxt = S_DONE;
        S_DONE:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      spk_lat   <= '0;
      shadow    <= '0;
      spike_out <= '0;
      step_done <= 1'b0;
      for (int i = 0; i < N_NEURONS; i++) begin
        v_mem[i] <= VREST_P;
        c_mem[i] <= '0;
      end
    end else begin
      step_done <= 1'b0;
      if (en) begin
        case (state)
          S_IDLE: begin
            if (step_start) begin
              spk_lat <= spike_in;
              idx     <= '0;
            end
          end
          S_RUN: begin
            v_mem[idx]  <= v_nxt;
            c_mem[idx]  <= c_nxt;
            shadow[idx] <= fire;
            if (idx != LAST_IDX) idx <= idx + IW'(1);
          end
          S_DONE: begin
            spike_out <= shadow;
            step_done <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign busy      = (state != S_IDLE);
  assign spike_any = |spike_out;

endmodule

// File: tb/tb_inhibitory_layer.sv
// Bench for inhibitory_layer: two 4-neuron instances (default constants and a
// saturation-stress variant) checked every cycle against a step-level model.
module tb_inhibitory_layer;

  localparam int N      = 4;
  localparam int VREST  = -15360;
  localparam int VRESET = -11520;
  localparam int LEAKC  = 254;
  localparam int REFR   = 2;

  int w_k  [2] = '{5120, 32767};
  int th_k [2] = '{-10240, 32767};

  logic         clk, rst_n;
  logic         en_a   [2];
  logic         ss_a   [2];
  logic [N-1:0] si_a   [2];
  logic         busy_a [2];
  logic         done_a [2];
  logic [N-1:0] so_a   [2];
  logic         any_a  [2];

  int checks = 0;
  int failures = 0;
  bit cmp_on = 0;

  inhibitory_layer #(.N_NEURONS(N)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en_a[0]), .step_start(ss_a[0]), .spike_in(si_a[0]),
    .busy(busy_a[0]), .step_done(done_a[0]), .spike_out(so_a[0]), .spike_any(any_a[0]));

  inhibitory_layer #(.N_NEURONS(N), .W_IN(32767), .V_THRES(32767)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en_a[1]), .step_start(ss_a[1]), .spike_in(si_a[1]),
    .busy(busy_a[1]), .step_done(done_a[1]), .spike_out(so_a[1]), .spike_any(any_a[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: whole timestep evaluated at acceptance, outputs published N+1 enabled cycles later.
  int       mv [2][N];
  int       mc [2][N];
  bit       m_run  [2];
  int       m_rem  [2];
  bit [N-1:0] m_res [2];
  bit [N-1:0] m_out [2];
  bit       m_done [2];

  function automatic int clamp(input longint x);
    if (x > 32767)  return 32767;
    if (x < -32768) return -32768;
    return int'(x);
  endfunction

  function automatic void model_step(input int k, input bit [N-1:0] s);
    int leak, u;
    for (int i = 0; i < N; i++) begin
      leak = clamp(VREST + ((longint'(clamp(mv[k][i] - VREST)) * LEAKC) >>> 8));
      m_res[k][i] = 1'b0;
      if (mc[k][i] > 0) begin
        mv[k][i] = leak;
        mc[k][i] = mc[k][i] - 1;
      end else begin
        u = clamp(longint'(leak) + (s[i] ? w_k[k] : 0));
        if (u >= th_k[k]) begin
          m_res[k][i] = 1'b1;
          mv[k][i] = VRESET;
          mc[k][i] = REFR;
        end else begin
          mv[k][i] = u;
        end
      end
    end
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_run[k] = 0; m_rem[k] = 0; m_res[k] = '0; m_out[k] = '0; m_done[k] = 0;
      for (int i = 0; i < N; i++) begin
        mv[k][i] = VREST;
        mc[k][i] = 0;
      end
    end
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) model_reset();
    else begin
      for (int k = 0; k < 2; k++) begin
        m_done[k] = 0;
        if (!m_run[k]) begin
          if (en_a[k] && ss_a[k]) begin
            model_step(k, si_a[k]);
            m_run[k] = 1;
            m_rem[k] = N + 1;
          end
        end else if (en_a[k]) begin
          m_rem[k] = m_rem[k] - 1;
          if (m_rem[k] == 0) begin
            m_run[k]  = 0;
            m_done[k] = 1;
            m_out[k]  = m_res[k];
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("busy%0d", k), busy_a[k], m_run[k]);
        chk($sformatf("step_done%0d", k), done_a[k], m_done[k]);
        chk($sformatf("spike_out%0d", k), so_a[k], m_out[k]);
        chk($sformatf("spike_any%0d", k), any_a[k], |m_out[k]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int k, input logic [N-1:0] s);
    ss_a[k] = 1'b1;
    si_a[k] = s;
    tick();
    ss_a[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, input int budget, output int cyc);
    cyc = 0;
    while (!done_a[k] && cyc < budget) begin
      tick();
      cyc++;
    end
    if (!done_a[k]) chk($sformatf("done_timeout%0d", k), 0, 1);
  endtask

  initial begin
    int lat;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      en_a[k] = 1'b1; ss_a[k] = 1'b0; si_a[k] = '0;
    end
    tick(); tick();
    cmp_on = 1;
    tick();
    chk("reset_busy", busy_a[0], 0);
    chk("reset_spike_out", so_a[0], 0);
    rst_n = 1'b1;
    tick();

    // Quiet step: latency N+1, nobody moves off rest.
    start(0, 4'b0000);
    wait_done(0, 20, lat);
    chk("lat_quiet", lat, N + 1);
    chk("quiet_out", so_a[0], 0);
    chk("model_v0_rest", mv[0][0], -15360);
    tick();

    // Single input spike from rest reaches threshold exactly.
    start(0, 4'b0100);
    wait_done(0, 20, lat);
    chk("single_out", so_a[0], 4'b0100);
    chk("single_any", any_a[0], 1);
    chk("model_v2_reset", mv[0][2], -11520);
    chk("model_c2", mc[0][2], 2);

    // Refractory: two silent steps, then fire again (back-to-back starts).
    start(0, 4'b0100);
    wait_done(0, 20, lat);
    chk("refrac1_out", so_a[0], 0);
    chk("model_v2_leak", mv[0][2], -11550);
    start(0, 4'b0100);
    wait_done(0, 20, lat);
    chk("refrac2_out", so_a[0], 0);
    start(0, 4'b0100);
    wait_done(0, 20, lat);
    chk("refire_out", so_a[0], 4'b0100);
    tick();

    // Pause for 3 cycles mid-run.
    start(0, 4'b1010);
    tick(); tick();
    en_a[0] = 1'b0;
    tick(); tick(); tick();
    en_a[0] = 1'b1;
    wait_done(0, 20, lat);
    chk("lat_paused", lat + 5, N + 1 + 3);
    chk("paused_out", so_a[0], 4'b1010);
    tick();

    // Reset mid-run clears outputs at once; next step behaves like the first.
    start(0, 4'b1111);
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy_a[0], 0);
    chk("midrst_out", so_a[0], 0);
    chk("midrst_any", any_a[0], 0);
    tick();
    rst_n = 1'b1;
    tick();
    start(0, 4'b0000);
    wait_done(0, 20, lat);
    chk("lat_after_rst", lat, N + 1);
    chk("after_rst_out", so_a[0], 0);
    tick();

    // Saturation instance: big weight, unreachable-without-saturation threshold.
    start(1, 4'b1111);
    wait_done(1, 20, lat);
    chk("sat1_out", so_a[1], 0);
    chk("model_sat_v", mv[1][0], 17407);
    start(1, 4'b1111);
    tick();
    start(1, 4'b0000);
    wait_done(1, 20, lat);
    chk("lat_busy_start", lat + 2, N + 1);
    chk("sat2_out", so_a[1], 4'b1111);
    tick();

    // Randomised traffic on both instances, occasional async reset.
    for (int n = 0; n < 800; n++) begin
      for (int k = 0; k < 2; k++) begin
        en_a[k] = ($urandom_range(0, 9) < 8);
        ss_a[k] = ($urandom_range(0, 2) == 0);
        si_a[k] = N'($urandom);
      end
      rst_n = ($urandom_range(0, 299) != 0);
      tick();
    end
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      en_a[k] = 1'b1; ss_a[k] = 1'b0;
    end
    repeat (10) tick();
    cmp_on = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
